pi_tx_nibble_rx: RTL and testbench

PI_TX_NIBBLE_RX -- requirements
Module: pi_tx_nibble_rx

---
 rtl/pi_tx_nibble_rx_pkg.sv | 17 +
 rtl/pi_tx_nibble_rx_if.sv | 12 +
 rtl/pi_tx_nibble_rx_fifo.sv | 55 +++++
 rtl/pi_tx_nibble_rx.sv | 110 +++++++++++
 tb/tb_pi_tx_nibble_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pi_tx_nibble_rx_pkg.sv
// Shared constants and types for the Pi TX nibble receiver.
package pi_tx_nibble_rx_pkg;

  localparam int SAMPLE_W           = 32;
  localparam int NIBBLE_W           = 4;
  localparam int NIBBLES_PER_SAMPLE = 8;
  localparam int NIB_CNT_W          = $clog2(NIBBLES_PER_SAMPLE);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // MSB-first assembly: earlier nibbles migrate toward the top of the word
  function automatic sample_t shift_nibble(input sample_t s, input nibble_t n);
    return {s[SAMPLE_W-NIBBLE_W-1:0], n};
  endfunction

endpackage

// File: rtl/pi_tx_nibble_rx_if.sv
// Sample stream (valid/ready) between the receiver and its downstream consumer.
interface pi_tx_nibble_rx_if;
  import pi_tx_nibble_rx_pkg::*;

  sample_t tx_tdata;
  logic    tx_tvalid;
  logic    tx_tready;

  modport master (output tx_tdata, output tx_tvalid, input tx_tready);
  modport slave  (input tx_tdata, input tx_tvalid, output tx_tready);

endinterface

// File: rtl/pi_tx_nibble_rx_fifo.sv
// Synchronous first-word-fall-through sample FIFO with occupancy count.
module tx_sample_fifo
  import pi_tx_nibble_rx_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  sample_t     wr_data,
  input  logic        rd_en,
  output sample_t     rd_data,
  output logic        rd_valid,
  output logic [AW:0] count,
  output logic        drop
);

  localparam int DEPTH = 1 << AW;

  sample_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;

  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pi_tx_nibble_rx.sv
// Receives 4-bit IQ nibbles strobed by the Pi, assembles 32-bit samples and
// buffers them in a FWFT FIFO with burst-sized flow control back to the Pi.
module pi_tx_nibble_rx
  import pi_tx_nibble_rx_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int BURST   = 16,
  parameter int IDLE_TO = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pi_tx_clk,
  input  nibble_t            pi_tx_data,
  output logic               pi_tx_samples,
  pi_tx_nibble_rx_if.master  tx,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  input  logic               clear_overflow
);

  localparam int IDLE_W = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] BURST_C = (FIFO_AW+1)'(BURST);

  logic [1:0]           clk_sync;
  nibble_t              data_s1;
  nibble_t              data_s2;
  logic                 clk_prev;
  logic [2:0]           warm;
  logic                 strobe;
  logic [NIB_CNT_W-1:0] nib_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  sample_t              sample_sr;
  logic                 wr_en;
  sample_t              wr_data;
  logic                 drop;
  logic [FIFO_AW:0]     free_entries;

  // Edge detection stays disarmed until the synchroniser holds real pin
  // history, so a strobe line already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
      clk_prev <= 1'b0;
      warm     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], pi_tx_clk};
      data_s1  <= pi_tx_data;
      data_s2  <= data_s1;
      clk_prev <= clk_sync[1];
      warm     <= {warm[1:0], 1'b1};
    end
  end

  assign strobe = warm[2] && clk_sync[1] && !clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      nib_cnt   <= '0;
      idle_cnt  <= '0;
      sample_sr <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (strobe) begin
        idle_cnt  <= '0;
        nib_cnt   <= nib_cnt + 1'b1;
        sample_sr <= shift_nibble(sample_sr, data_s2);
        if (nib_cnt == NIB_CNT_W'(NIBBLES_PER_SAMPLE - 1)) begin
          wr_en   <= 1'b1;
          wr_data <= shift_nibble(sample_sr, data_s2);
        end
      end else if (idle_cnt == IDLE_W'(IDLE_TO)) begin
        nib_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  tx_sample_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (tx.tx_tready),
    .rd_data  (tx.tx_tdata),
    .rd_valid (tx.tx_tvalid),
    .count    (fifo_count),
    .drop     (drop)
  );

  assign free_entries = DEPTH_C - fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow      <= 1'b0;
      pi_tx_samples <= 1'b0;
    end else begin
      overflow      <= drop || (overflow && !clear_overflow);
      pi_tx_samples <= (free_entries >= BURST_C);
    end
  end

endmodule

// File: tb/tb_pi_tx_nibble_rx.sv
// Scoreboard bench for pi_tx_nibble_rx: stimulus queues expected samples,
// a negedge monitor pops and compares every accepted output word.
module tb_pi_tx_nibble_rx;
  import pi_tx_nibble_rx_pkg::*;

  localparam int FIFO_AW = 10;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic               clk = 1'b0;
  logic               rst;
  logic               pi_tx_clk;
  logic [3:0]         pi_tx_data;
  logic               pi_tx_samples;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;
  logic               clear_overflow;

  pi_tx_nibble_rx_if bus ();

  pi_tx_nibble_rx #(
    .FIFO_AW (FIFO_AW),
    .BURST   (16),
    .IDLE_TO (255)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pi_tx_clk      (pi_tx_clk),
    .pi_tx_data     (pi_tx_data),
    .pi_tx_samples  (pi_tx_samples),
    .tx             (bus),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  bit          rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.tx_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_nibble(input logic [3:0] n);
    pi_tx_data = n;
    pi_tx_clk  = 1'b0;
    tick(); tick();
    pi_tx_clk  = 1'b1;
    tick(); tick();
  endtask

  task automatic send_head(input logic [31:0] s);
    for (int i = 0; i < 7; i++) send_nibble(s[31-4*i -: 4]);
  endtask

  // Leaves the final rising edge just driven so callers can time its effects
  task automatic raise_last(input logic [3:0] n);
    pi_tx_data = n;
    pi_tx_clk  = 1'b0;
    tick(); tick();
    pi_tx_clk  = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [31:0] s, input bit expect_out);
    if (expect_out) exp_q.push_back(s);
    for (int i = 0; i < 8; i++) send_nibble(s[31-4*i -: 4]);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] gen(input int i);
    return {16'(i), ~16'(i)};
  endfunction

  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.tx_tvalid === 1'b1 && bus.tx_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_output: got 0x%08h expected no output", bus.tx_tdata);
        end else begin
          exp = exp_q.pop_front();
          check_output("stream_data", bus.tx_tdata, exp);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    logic [31:0] s;
    rst            = 1'b1;
    pi_tx_clk      = 1'b0;
    pi_tx_data     = 4'h0;
    clear_overflow = 1'b0;
    bus.tx_tready  = 1'b0;
    repeat (4) tick();
    check_output("rst_samples", 32'(pi_tx_samples), 32'd0);
    check_output("rst_tvalid",  32'(bus.tx_tvalid), 32'd0);
    check_output("rst_tdata",   bus.tx_tdata,       32'd0);
    check_output("rst_count",   32'(fifo_count),    32'd0);
    check_output("rst_ovf",     32'(overflow),      32'd0);
    rst = 1'b0;
    tick();
    check_output("samples_after_rst", 32'(pi_tx_samples), 32'd1);
    repeat (3) tick();

    $display("[TB] basic sample 0x12345678 with latency check");
    exp_q.push_back(32'h12345678);
    send_head(32'h12345678);
    raise_last(4'h8);
    repeat (3) tick();
    check_output("tvalid_strobe_plus1", 32'(bus.tx_tvalid), 32'd0);
    tick();
    check_output("tvalid_strobe_plus2", 32'(bus.tx_tvalid), 32'd1);
    check_output("count_one",           32'(fifo_count),    32'd1);
    check_output("head_12345678",       bus.tx_tdata,       32'h12345678);
    tick();
    bus.tx_tready = 1'b1;
    wait_drain(50);

    $display("[TB] partial sample discarded by idle timeout");
    send_nibble(4'h1); send_nibble(4'h2); send_nibble(4'h3);
    repeat (300) tick();
    apply_stimulus(32'hABCD0123, 1'b1);
    wait_drain(50);
    repeat (5) tick();
    check_output("idle_tvalid", 32'(bus.tx_tvalid), 32'd0);
    check_output("idle_count",  32'(fifo_count),    32'd0);

    $display("[TB] fill FIFO with tready low");
    bus.tx_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(gen(i), 1'b1);
      if (i == 1007) begin
        repeat (5) tick();
        check_output("count_1008",   32'(fifo_count),    32'd1008);
        check_output("samples_1008", 32'(pi_tx_samples), 32'd1);
      end else if (i == 1008) begin
        repeat (5) tick();
        check_output("count_1009",   32'(fifo_count),    32'd1009);
        check_output("samples_1009", 32'(pi_tx_samples), 32'd0);
      end
    end
    repeat (5) tick();
    check_output("full_count", 32'(fifo_count), 32'd1024);
    check_output("full_ovf",   32'(overflow),   32'd0);
    check_output("full_head",  bus.tx_tdata,    gen(0));
    apply_stimulus(gen(DEPTH), 1'b0);
    repeat (5) tick();
    check_output("drop_ovf",   32'(overflow),   32'd1);
    check_output("drop_count", 32'(fifo_count), 32'd1024);
    check_output("drop_head",  bus.tx_tdata,    gen(0));
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_output("ovf_cleared", 32'(overflow), 32'd0);

    $display("[TB] write into full FIFO coinciding with a pop");
    s = gen(DEPTH + 1);
    exp_q.push_back(s);
    send_head(s);
    raise_last(s[3:0]);
    repeat (3) tick();
    bus.tx_tready = 1'b1;
    tick();
    bus.tx_tready = 1'b0;
    repeat (3) tick();
    check_output("pushpop_count", 32'(fifo_count), 32'd1024);
    check_output("pushpop_ovf",   32'(overflow),   32'd0);
    check_output("pushpop_head",  bus.tx_tdata,    gen(1));
    bus.tx_tready = 1'b1;
    wait_drain(1200);

    $display("[TB] random stream with random tready");
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) apply_stimulus($urandom, 1'b1);
    rand_ready = 1'b0;
    bus.tx_tready = 1'b1;
    wait_drain(200);
    check_output("stream_ovf", 32'(overflow), 32'd0);

    $display("[TB] reset mid-sample");
    bus.tx_tready = 1'b0;
    apply_stimulus(32'h55AA55AA, 1'b0);
    for (int i = 0; i < 5; i++) send_nibble(4'(i + 3));
    rst       = 1'b1;
    pi_tx_clk = 1'b1;
    tick(); tick();
    check_output("mid_rst_tvalid",  32'(bus.tx_tvalid), 32'd0);
    check_output("mid_rst_tdata",   bus.tx_tdata,       32'd0);
    check_output("mid_rst_count",   32'(fifo_count),    32'd0);
    check_output("mid_rst_ovf",     32'(overflow),      32'd0);
    check_output("mid_rst_samples", 32'(pi_tx_samples), 32'd0);
    rst = 1'b0;
    tick();
    check_output("post_rst_samples", 32'(pi_tx_samples), 32'd1);
    repeat (6) tick();
    check_output("no_spurious_count", 32'(fifo_count), 32'd0);
    bus.tx_tready = 1'b1;
    apply_stimulus(32'hFEDCBA98, 1'b1);
    wait_drain(50);
    repeat (3) tick();
    check_output("final_count", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
